// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
`timescale 1ns/1ps
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Values of a_ns selecting the operation
    localparam logic ADD = 1'b1;
    localparam logic SUB = 1'b0;

endpackage

// File: rtl/serial_addsub_fas.sv
// One-bit full adder/subtractor cell.
// a_ns = 1 adds a, a_ns = 0 adds ~a (the +1 of a subtract arrives through cin).
// The delay parameters describe the gate path used for clock budgeting;
// the logic itself is modelled with zero delay.
`timescale 1ns/1ps
module serial_addsub_fas #(
    parameter int nand_tpd = 1,
    parameter int or_tpd   = 1,
    parameter int xnor_tpd = 1
) (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic a_ns,
    output logic s,
    output logic cout
);

    logic a_eff;
    logic prop;
    logic gen_n;
    logic prop_n;

    if (nand_tpd < 0 || or_tpd < 0 || xnor_tpd < 0) begin : g_bad_tpd
        $error("serial_addsub_fas: gate delays must be non-negative");
    end

    assign a_eff  = ~(a ^ a_ns);
    assign prop   = a_eff ^ b;
    assign s      = prop ^ cin;
    assign gen_n  = ~(a_eff & b);
    assign prop_n = ~(prop & cin);
    assign cout   = ~(gen_n & prop_n);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: feeds one fas cell LSB-first,
// one bit per clock, and collects the sum bits into a result register.
`timescale 1ns/1ps
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NAND_TPD = 1,
    parameter int OR_TPD   = 1,
    parameter int XNOR_TPD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             a_ns_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_addsub: WIDTH must be at least 2");
    end

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [CNT_W-1:0] bit_cnt;
    logic             carry_reg;
    logic             op_reg;
    logic             fas_s;
    logic             fas_cout;

    serial_addsub_fas #(
        .nand_tpd (NAND_TPD),
        .or_tpd   (OR_TPD),
        .xnor_tpd (XNOR_TPD)
    ) u_fas (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry_reg),
        .a_ns (op_reg),
        .s    (fas_s),
        .cout (fas_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; a start in DONE is accepted so operations can run back-to-back
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bit_cnt == LAST_BIT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign result = res_sh;

    // Operand capture, serial shifting, carry flop and final flag latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            bit_cnt   <= '0;
            carry_reg <= 1'b0;
            op_reg    <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_sh      <= a_in;
            b_sh      <= b_in;
            op_reg    <= a_ns_in;
            carry_reg <= (a_ns_in == SUB);
            bit_cnt   <= '0;
        end else if (state == RUN) begin
            res_sh    <= {fas_s, res_sh[WIDTH-1:1]};
            carry_reg <= fas_cout;
            a_sh      <= a_sh >> 1;
            b_sh      <= b_sh >> 1;
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
                carry_out <= fas_cout;
                overflow  <= carry_reg ^ fas_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub against an arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_addsub;
    import serial_addsub_pkg::*;

    localparam int W = 8;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         start   = 1'b0;
    logic [W-1:0] a_in    = '0;
    logic [W-1:0] b_in    = '0;
    logic         a_ns_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_addsub #(
        .WIDTH    (W),
        .NAND_TPD (1),
        .OR_TPD   (1),
        .XNOR_TPD (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .a_ns_in   (a_ns_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {overflow, carry_out, result} from plain integer arithmetic
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic op);
        int ua;
        int ub;
        int sa;
        int sb;
        int r;
        int sr;
        logic c;
        logic v;
        logic [31:0] rv;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (op == ADD) begin
            r  = ub + ua;
            c  = (r > 255);
            sr = sb + sa;
        end else begin
            r  = ub - ua;
            c  = (ub >= ua);
            sr = sb - sa;
        end
        v  = (sr > 127) || (sr < -128);
        rv = 32'(r);
        return {v, c, rv[7:0]};
    endfunction

    // Runs one operation. pre: start/operands were already driven by the
    // previous call. chain: drive the next operation's start in the done cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic op,
                          input int inj_cyc, input bit pre, input bit chain,
                          input logic [7:0] na, input logic [7:0] nb, input logic nop,
                          input string tag);
        logic [9:0] exp;
        int busy_n;
        int done_cyc;
        exp      = model(a, b, op);
        busy_n   = 0;
        done_cyc = 0;
        if (!pre) begin
            a_in    = a;
            b_in    = b;
            a_ns_in = op;
            start   = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk);
                #1;
            end
            if (cyc == inj_cyc) begin
                a_in    = ~a;
                b_in    = a ^ b ^ 8'h5a;
                a_ns_in = ~op;
                start   = 1'b1;
            end else if (cyc == inj_cyc + 1) begin
                start = 1'b0;
            end
            if (busy) busy_n++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        check({tag, "/done_cyc"}, 32'(done_cyc), 32'd9);
        check({tag, "/busy_cycles"}, 32'(busy_n), 32'd8);
        check({tag, "/result"}, 32'(result), 32'(exp[7:0]));
        check({tag, "/carry_out"}, 32'(carry_out), 32'(exp[8]));
        check({tag, "/overflow"}, 32'(overflow), 32'(exp[9]));
        if (chain) begin
            a_in    = na;
            b_in    = nb;
            a_ns_in = nop;
            start   = 1'b1;
        end else begin
            @(posedge clk);
            #1;
            check({tag, "/done_one_cycle"}, 32'(done), 32'd0);
            check({tag, "/result_held"}, 32'(result), 32'(exp[7:0]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rop;
        logic [7:0] nra;
        logic [7:0] nrb;
        logic       nrop;
        bit         pre;
        bit         chain;
        int         done_seen;

        repeat (2) @(posedge clk);
        #1;
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/done", 32'(done), 32'd0);
        check("reset/result", 32'(result), 32'd0);
        check("reset/carry_out", 32'(carry_out), 32'd0);
        check("reset/overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'h05, 8'h3C, ADD, 0, 0, 0, 8'h00, 8'h00, ADD, "add_basic");
        run_op(8'h07, 8'h05, SUB, 0, 0, 0, 8'h00, 8'h00, ADD, "sub_borrow");
        run_op(8'h01, 8'h7F, ADD, 0, 0, 0, 8'h00, 8'h00, ADD, "add_ovf");
        run_op(8'h01, 8'hFF, ADD, 0, 0, 0, 8'h00, 8'h00, ADD, "add_carry");
        run_op(8'h01, 8'h80, SUB, 0, 0, 0, 8'h00, 8'h00, ADD, "sub_ovf");

        // start during RUN is ignored; start in the done cycle chains
        run_op(8'h22, 8'h44, ADD, 3, 0, 1, 8'h9C, 8'h33, SUB, "run_start_ignored");
        run_op(8'h9C, 8'h33, SUB, 0, 1, 0, 8'h00, 8'h00, ADD, "back_to_back");

        // Asynchronous reset in the middle of an operation
        a_in    = 8'hF3;
        b_in    = 8'h6E;
        a_ns_in = ADD;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/done", 32'(done), 32'd0);
        check("abort/result", 32'(result), 32'd0);
        check("abort/carry_out", 32'(carry_out), 32'd0);
        check("abort/overflow", 32'(overflow), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        check("abort/no_done_after_release", 32'(done_seen), 32'd0);
        run_op(8'h10, 8'h20, ADD, 0, 0, 0, 8'h00, 8'h00, ADD, "after_reset");

        // Randomized operations, some chained back-to-back
        ra  = 8'($urandom);
        rb  = 8'($urandom);
        rop = 1'($urandom);
        pre = 1'b0;
        for (int i = 0; i < 24; i++) begin
            nra   = 8'($urandom);
            nrb   = 8'($urandom);
            nrop  = 1'($urandom);
            chain = (i < 23) && ($urandom_range(0, 1) == 1);
            run_op(ra, rb, rop, 0, pre, chain, nra, nrb, nrop, "random");
            ra  = nra;
            rb  = nrb;
            rop = nrop;
            pre = chain;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial WIDTH-bit adder/subtractor controller built around one fas full adder/subtractor cell.
- Captures operands, drives the cell LSB-first one bit per clock, registers the carry between bits, and shifts sum bits into a result register.
- Sits directly upstream of the fas cell, feeding a/b/cin/a_ns, and directly downstream of it, consuming s/cout.
- Gives the datapath a multi-bit add/sub from a single gate-level cell.

Parameters:
- WIDTH, 8: operand/result width in bits; must be ≥ 2.
- NAND_TPD, 1: passed to the fas nand_tpd.
- OR_TPD, 1: passed to the fas or_tpd.
- XNOR_TPD, 1: passed to the fas xnor_tpd.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on the rising edge of clk.
- a_in  input  WIDTH  operand A, captured at an accepted start.
- b_in  input  WIDTH  operand B, captured at an accepted start.
- a_ns_in  input  1  1 = add (B+A); 0 = subtract (B−A). Captured at an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  WIDTH  sum/difference; held until the next accepted start.
- carry_out  output  1  final cout. For subtract, 1 = no borrow (B ≥ A unsigned).
- overflow  output  1  two's-complement overflow of the operation.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, internal shift/count/carry registers=0. Reset asserted mid-operation aborts the operation; no done pulse follows.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1: capture a_in, b_in and a_ns_in into shift registers; carry_reg ← ~a_ns_in; bit_cnt ← 0; go to RUN.
  - RUN: busy=1. Every edge: shift fas.s into the result register at the MSB end (right shift); carry_reg ← fas.cout; shift both operand registers right; bit_cnt++.
  - RUN, bit_cnt == WIDTH−1: on that edge also latch carry_out ← cout and overflow ← carry_reg XOR cout (carry into MSB vs. carry out of MSB); go to DONE.
  - DONE: done=1 for exactly one cycle; busy=0. Go to IDLE. A start seen in DONE is accepted exactly as in IDLE (back-to-back operation).
  - start while in RUN is ignored; operands are not recaptured.
- fas hookup:
  - a = A-register bit 0; b = B-register bit 0; cin = carry_reg; a_ns = captured a_ns.
  - Subtract is therefore B + ~A + 1.
- Latency: start accepted at edge 0 → WIDTH RUN cycles → done high in the cycle after edge WIDTH. result, carry_out and overflow are valid with done and held afterwards.
- Timing: the fas output is combinational with gate delays. The clock period must exceed 2·NAND_TPD + max(OR_TPD, XNOR_TPD) + NAND_TPD. The bench uses a period of 10 units or more with default delays.
- result is written only during RUN. During RUN it holds partial bits; the bench checks it only at done.

Decomposition:
- Package serial_addsub_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - ADD=1'b1, SUB=1'b0 constants for a_ns.
- Sub-module: one fas instance, delay parameters passed through. All other logic (FSM, counter, shift registers, carry flop) stays in this module.
- bit_cnt width is $clog2(WIDTH).

Test Plan:
- WIDTH=8, add a_in=0x05, b_in=0x3C → result=0x41, carry_out=0, overflow=0; done exactly 9 cycles after the start edge; busy high for cycles 1–8.
- Subtract a_in=0x07, b_in=0x05 → result=0xFE, carry_out=0 (borrow), overflow=0.
- Add 0x01+0x7F → result=0x80, overflow=1, carry_out=0. Add 0x01+0xFF → result=0x00, carry_out=1, overflow=0.
- Subtract a_in=0x01, b_in=0x80 → result=0x7F, carry_out=1, overflow=1.
- start pulsed at cycle 3 of RUN with different operands → ignored; first result is unchanged. Then start in the done cycle → second operation begins immediately and completes correctly.
- rst_n low at RUN cycle 4 → all outputs 0 immediately (asynchronous), no done pulse. After release, a new add 0x10+0x20 → 0x30.
